// File: rtl/cargador_programa.sv
// Program loader: packs UART bytes MSB-first into instructions and writes them to
// consecutive program-memory addresses until the HALT word is stored or memory fills.
module cargador_programa #(
    parameter int                   RAM_WIDTH  = 32,
    parameter int                   RAM_DEPTH  = 2048,
    parameter int                   ADDR_WIDTH = $clog2(RAM_DEPTH + 1),
    parameter logic [RAM_WIDTH-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_ena,
    output logic                  o_wea,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [RAM_WIDTH-1:0]  o_dina,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic [ADDR_WIDTH:0]   o_word_count
);

    localparam int NBYTES = RAM_WIDTH / 8;
    localparam int BCW    = $clog2(NBYTES + 1);

    localparam logic [BCW-1:0]        LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [RAM_WIDTH-1:0]    shreg_r;
    logic [RAM_WIDTH-1:0]    word_s;
    logic [BCW-1:0]          byte_cnt_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    ena_s;
    logic                    busy_s;
    logic                    done_s;
    logic                    ovf_s;

    assign word_s = {shreg_r[RAM_WIDTH-9:0], i_rx_data};

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    state_nxt_s = ST_RECV;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RECV: begin
                if (i_rx_valid && (byte_cnt_r == LAST_BYTE)) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_RECV;
                end
            end
            ST_WRITE: begin
                // HALT wins over overflow when it lands on the last address
                if (o_dina == HALT_WORD) begin
                    state_nxt_s = ST_DONE;
                end else if (addr_r == LAST_ADDR) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    state_nxt_s = ST_RECV;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the registered flags line up with the state
    always_comb begin
        ena_s  = 1'b0;
        busy_s = 1'b0;
        done_s = 1'b0;
        ovf_s  = 1'b0;
        case (state_nxt_s)
            ST_RECV: begin
                busy_s = 1'b1;
            end
            ST_WRITE: begin
                ena_s  = 1'b1;
                busy_s = 1'b1;
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            ST_ERROR: begin
                ovf_s = 1'b1;
            end
            default: begin
                ena_s = 1'b0;
            end
        endcase
    end

    // Datapath: byte assembly, address/count tracking and registered outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shreg_r      <= '0;
            byte_cnt_r   <= '0;
            addr_r       <= '0;
            o_ena        <= 1'b0;
            o_wea        <= 1'b0;
            o_addr       <= '0;
            o_dina       <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_overflow   <= 1'b0;
            o_word_count <= '0;
        end else begin
            o_ena      <= ena_s;
            o_wea      <= ena_s;
            o_busy     <= busy_s;
            o_done     <= done_s;
            o_overflow <= ovf_s;
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (i_start) begin
                        addr_r       <= '0;
                        byte_cnt_r   <= '0;
                        o_word_count <= '0;
                    end
                end
                ST_RECV: begin
                    if (i_rx_valid) begin
                        shreg_r <= word_s;
                        if (byte_cnt_r == LAST_BYTE) begin
                            byte_cnt_r <= '0;
                            o_dina     <= word_s;
                            o_addr     <= addr_r;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + BCW'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    o_word_count <= o_word_count + (ADDR_WIDTH + 1)'(1);
                    if (state_nxt_s == ST_RECV) begin
                        addr_r <= addr_r + ADDR_WIDTH'(1);
                    end
                    // A byte arriving during the write strobe starts the next word
                    if (i_rx_valid) begin
                        shreg_r    <= word_s;
                        byte_cnt_r <= BCW'(1);
                    end
                end
                default: begin
                    byte_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule
